// File: rtl/prog_loader.sv
// prog_loader: nibble-serial program loader for the instruction memory.
// Host handshakes nibbles in 4-phase; a checksum closes each load.
module prog_loader #(
    parameter int IMEM_SZ     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_req_in,
    input  logic [3:0] nib_in,
    input  logic       nib_strobe_in,
    output logic       ack_out,
    output logic       imem_we_out,
    output logic [3:0] imem_addr_out,
    output logic [7:0] imem_data_out,
    output logic       cpu_hold_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       err_out
);

    typedef enum logic [3:0] {
        S_IDLE, S_LO, S_HI, S_WRITE, S_CS_LO,
        S_CS_HI, S_CHECK, S_DONE, S_ERR
    } state_e;

    localparam logic [3:0] LAST = 4'(IMEM_SZ - 1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] load_sync_q, stb_sync_q;
    logic                   load_prev_q, stb_prev_q;
    logic                   ack_q, ack_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [7:0]             cs_q, cs_d;
    logic [7:0]             data_q, data_d;

    logic load_s, stb_s;
    logic load_rise, load_fall, stb_rise;
    logic in_load, nib_state, capture;

    assign load_s    = load_sync_q[SYNC_STAGES-1];
    assign stb_s     = stb_sync_q[SYNC_STAGES-1];
    assign load_rise = load_s & ~load_prev_q;
    assign load_fall = ~load_s & load_prev_q;
    assign stb_rise  = stb_s & ~stb_prev_q;

    assign in_load = (state_q == S_LO) || (state_q == S_HI) ||
                     (state_q == S_WRITE) || (state_q == S_CS_LO) ||
                     (state_q == S_CS_HI) || (state_q == S_CHECK);

    assign nib_state = (state_q == S_LO) || (state_q == S_HI) ||
                       (state_q == S_CS_LO) || (state_q == S_CS_HI);

    // An abort in the same cycle as a strobe edge wins; nibble is dropped.
    assign capture = stb_rise & ~ack_q & nib_state & ~load_fall;

    // Pin synchronizers, edge-detect history and FSM/datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_sync_q <= '0;
            stb_sync_q  <= '0;
            load_prev_q <= 1'b0;
            stb_prev_q  <= 1'b0;
            state_q     <= S_IDLE;
            ack_q       <= 1'b0;
            cnt_q       <= '0;
            cs_q        <= '0;
            data_q      <= '0;
        end else begin
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], load_req_in};
            stb_sync_q  <= {stb_sync_q[SYNC_STAGES-2:0], nib_strobe_in};
            load_prev_q <= load_s;
            stb_prev_q  <= stb_s;
            state_q     <= state_d;
            ack_q       <= ack_d;
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            data_q      <= data_d;
        end
    end

    // Next-state, nibble assembly, checksum and handshake logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        data_d  = data_q;
        ack_d   = ack_q;

        if (capture)
            ack_d = 1'b1;
        else if (ack_q && !stb_s)
            ack_d = 1'b0;

        if (in_load && load_fall) begin
            state_d = S_ERR;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_rise) begin
                        state_d = S_LO;
                        cnt_d   = '0;
                        cs_d    = '0;
                    end
                end
                S_LO: begin
                    if (capture) begin
                        data_d[3:0] = nib_in;
                        state_d     = S_HI;
                    end
                end
                S_HI: begin
                    if (capture) begin
                        data_d[7:4] = nib_in;
                        state_d     = S_WRITE;
                    end
                end
                S_WRITE: begin
                    cs_d = cs_q + data_q;
                    if (cnt_q == LAST) begin
                        state_d = S_CS_LO;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = S_LO;
                    end
                end
                S_CS_LO: begin
                    if (capture) begin
                        data_d[3:0] = nib_in;
                        state_d     = S_CS_HI;
                    end
                end
                S_CS_HI: begin
                    if (capture) begin
                        data_d[7:4] = nib_in;
                        state_d     = S_CHECK;
                    end
                end
                S_CHECK: begin
                    state_d = (data_q == cs_q) ? S_DONE : S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign ack_out       = ack_q;
    assign imem_we_out   = (state_q == S_WRITE);
    assign imem_addr_out = cnt_q;
    assign imem_data_out = data_q;
    assign busy_out      = in_load;
    assign done_out      = (state_q == S_DONE);
    assign err_out       = (state_q == S_ERR);
    assign cpu_hold_out  = in_load | (state_q == S_ERR);

endmodule
